// File: rtl/traffic_pkg.sv
// Light encodings shared by the traffic-light controller and the street model.
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b00;
  localparam logic [1:0] LIGHT_YELLOW = 2'b01;
  localparam logic [1:0] LIGHT_RED    = 2'b10;

endpackage

// File: rtl/sensor_lane.sv
// One street of the closed-loop traffic model.
// Cars queue on arrival edges and drain at one car per DEPART_CYCLES while green.
module sensor_lane
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          car,
  input  logic [1:0]    light,
  output logic [QW-1:0] q,
  output logic          occ,
  output logic          ovf
);

  localparam int            TW       = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(DEPART_CYCLES - 1);
  localparam logic [QW-1:0] Q_MAX    = {QW{1'b1}};

  logic          car_d;
  logic [TW-1:0] tmr;
  logic          arr;
  logic          green;
  logic          tmr_run;
  logic          dep;

  assign arr     = car & ~car_d;
  assign green   = (light == LIGHT_GREEN);
  assign tmr_run = green && (q != '0);
  assign dep     = tmr_run && (tmr == TMR_LAST);
  assign occ     = (q != '0);

  // car_d follows car even in reset, so a level already high at release is not an arrival.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      car_d <= car;
      tmr   <= '0;
      q     <= '0;
      ovf   <= 1'b0;
    end else begin
      car_d <= car;

      if (!tmr_run || dep)
        tmr <= '0;
      else
        tmr <= tmr + TW'(1);

      case ({arr, dep})
        2'b10: begin
          if (q != Q_MAX)
            q <= q + QW'(1);
          else
            ovf <= 1'b1;
        end
        2'b01:   q <= q - QW'(1);
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/traffic_sensor.sv
// Two-street vehicle-presence model feeding the traffic-light controller.
// Wiring only: each street is an independent sensor_lane.
module traffic_sensor
  import traffic_pkg::*;
#(
  parameter int QW            = 4,
  parameter int DEPART_CYCLES = 3
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          car_a,
  input  logic          car_b,
  input  logic [1:0]    L_A,
  input  logic [1:0]    L_B,
  output logic          T_A,
  output logic          T_B,
  output logic [QW-1:0] q_a,
  output logic [QW-1:0] q_b,
  output logic          ovf_a,
  output logic          ovf_b
);

  sensor_lane #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_lane_a (
    .CLK    (CLK),
    .resetn (resetn),
    .car    (car_a),
    .light  (L_A),
    .q      (q_a),
    .occ    (T_A),
    .ovf    (ovf_a)
  );

  sensor_lane #(.QW(QW), .DEPART_CYCLES(DEPART_CYCLES)) u_lane_b (
    .CLK    (CLK),
    .resetn (resetn),
    .car    (car_b),
    .light  (L_B),
    .q      (q_b),
    .occ    (T_B),
    .ovf    (ovf_b)
  );

endmodule
